// File: rtl/maccum_tile_scheduler_if.sv
// Bundle of the upstream state channel, tile memory port and the two Maccum-facing
// channels. The master modport is the scheduler; the slave modport is its surroundings.
interface maccum_tile_scheduler_if #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WF = 4,
  parameter int NT = 3,
  parameter int AW = 8
);
  localparam int WWB = NC*NP*WF + NC*WF;
  localparam int TW  = (NT > 1) ? $clog2(NT) : 1;

  logic              iValid_AM_State;
  logic              oReady_AM_State;
  logic [NP*WF-1:0]  iData_AM_State;
  logic              oRdEn;
  logic [AW-1:0]     oRdAddr;
  logic [WWB-1:0]    iRdData;
  logic              oValid_BM_WeightBias;
  logic              iReady_BM_WeightBias;
  logic [WWB-1:0]    oData_BM_WeightBias;
  logic              oValid_BM_State0;
  logic              iReady_BM_State0;
  logic [NP*WF-1:0]  oData_BM_State0;
  logic [TW-1:0]     oTile;
  logic              oBusy;
  logic              oDone;
  logic [1:0]        dbg_state;

  modport master (
    input  iValid_AM_State, iData_AM_State, iRdData,
           iReady_BM_WeightBias, iReady_BM_State0,
    output oReady_AM_State, oRdEn, oRdAddr,
           oValid_BM_WeightBias, oData_BM_WeightBias,
           oValid_BM_State0, oData_BM_State0,
           oTile, oBusy, oDone, dbg_state
  );

  modport slave (
    output iValid_AM_State, iData_AM_State, iRdData,
           iReady_BM_WeightBias, iReady_BM_State0,
    input  oReady_AM_State, oRdEn, oRdAddr,
           oValid_BM_WeightBias, oData_BM_WeightBias,
           oValid_BM_State0, oData_BM_State0,
           oTile, oBusy, oDone, dbg_state
  );
endinterface

// File: rtl/maccum_tile_scheduler.sv
// Streams NT weight/bias tiles from a 1-cycle-latency memory, pairing each with a
// replayed copy of one latched input state vector for a single Maccum instance.
module maccum_tile_scheduler #(
  parameter int NP   = 4,
  parameter int NC   = 4,
  parameter int WF   = 4,
  parameter int NT   = 3,
  parameter int BASE = 0,
  parameter int AW   = 8
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  maccum_tile_scheduler_if.master bus
);
  localparam int WWB = NC*NP*WF + NC*WF;
  localparam int TW  = (NT > 1) ? $clog2(NT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2, ISSUE = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tile_q, tile_d;
  logic [NP*WF-1:0] st_q, st_d;
  logic [WWB-1:0]   wb_q, wb_d;
  logic             wb_vld_q, wb_vld_d;
  logic             s0_vld_q, s0_vld_d;
  logic             wb_hs, s0_hs, tile_done, last_tile;

  // Handshake: a transfer happens on a rising clock edge where valid and ready are both
  // high; valid and data are held while valid && !ready, and valid drops after transfer.
  assign wb_hs     = wb_vld_q & bus.iReady_BM_WeightBias;
  assign s0_hs     = s0_vld_q & bus.iReady_BM_State0;
  // A tile is finished when neither channel still has a transfer outstanding.
  assign tile_done = (!wb_vld_q | wb_hs) & (!s0_vld_q | s0_hs);
  assign last_tile = (tile_q == TW'(NT-1));

  assign bus.oReady_AM_State      = (state_q == IDLE) & ~iRST;
  assign bus.oRdAddr              = AW'(BASE) + AW'(tile_q);
  assign bus.oValid_BM_WeightBias = wb_vld_q;
  assign bus.oData_BM_WeightBias  = wb_q;
  assign bus.oValid_BM_State0     = s0_vld_q;
  assign bus.oData_BM_State0      = st_q;
  assign bus.oTile                = tile_q;
  assign bus.oBusy                = (state_q != IDLE);
  assign bus.dbg_state            = state_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      st_q     <= '0;
      wb_q     <= '0;
      wb_vld_q <= 1'b0;
      s0_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      st_q     <= st_d;
      wb_q     <= wb_d;
      wb_vld_q <= wb_vld_d;
      s0_vld_q <= s0_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    st_d      = st_q;
    wb_d      = wb_q;
    wb_vld_d  = wb_vld_q;
    s0_vld_d  = s0_vld_q;
    bus.oRdEn = 1'b0;
    bus.oDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iValid_AM_State) begin
          st_d    = bus.iData_AM_State;
          tile_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        bus.oRdEn = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        wb_d     = bus.iRdData;
        wb_vld_d = 1'b1;
        s0_vld_d = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (wb_hs) wb_vld_d = 1'b0;
        if (s0_hs) s0_vld_d = 1'b0;
        if (tile_done) begin
          if (last_tile) begin
            bus.oDone = 1'b1;
            state_d   = IDLE;
          end else begin
            tile_d  = tile_q + TW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_maccum_tile_scheduler.sv
// Directed bench for maccum_tile_scheduler: table of vectors with per-channel sink
// latencies, plus sequences for back-to-back input, mid-flight reset and address wrap.
module tb_maccum_tile_scheduler;
  localparam int NP  = 4;
  localparam int NC  = 4;
  localparam int WF  = 4;
  localparam int NT  = 3;
  localparam int AW  = 8;
  localparam int WWB = NC*NP*WF + NC*WF;
  localparam int SW  = NP*WF;
  localparam int TW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maccum_tile_scheduler_if #(.NP(NP), .NC(NC), .WF(WF), .NT(NT), .AW(AW)) bus ();
  maccum_tile_scheduler_if #(.NP(NP), .NC(NC), .WF(WF), .NT(NT), .AW(AW)) bus_b ();

  maccum_tile_scheduler #(.NP(NP), .NC(NC), .WF(WF), .NT(NT), .BASE(0), .AW(AW)) u_dut (
    .iCLK(clk), .iRST(rst), .bus(bus)
  );
  maccum_tile_scheduler #(.NP(NP), .NC(NC), .WF(WF), .NT(NT), .BASE(254), .AW(AW)) u_dut_b (
    .iCLK(clk), .iRST(rst), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [WWB-1:0] act, input logic [WWB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: tile at address a holds a+0x10, returned the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.oRdEn) bus.iRdData <= WWB'(bus.oRdAddr) + WWB'(16);
  end

  // Scoreboard
  logic [WWB-1:0] wb_exp_q[$];
  logic [SW-1:0]  st_exp_q[$];
  logic [TW-1:0]  tile_exp_q[$];

  int             wb_lat = 0, st_lat = 0, wb_cnt = 0, st_cnt = 0, fetch_k = 0;
  logic           wb_stall = 1'b0, st_stall = 1'b0;
  logic [WWB-1:0] wb_prev;
  logic [SW-1:0]  st_prev;
  logic [AW-1:0]  addr_b_q[$];
  int             done_b = 0;

  // Sinks drive ready after a programmable number of stalled cycles; monitor checks transfers.
  always @(negedge clk) begin
    if (rst) begin
      wb_stall = 1'b0; st_stall = 1'b0; wb_cnt = 0; st_cnt = 0; fetch_k = 0;
    end else begin
      bus.iReady_BM_WeightBias = (wb_cnt >= wb_lat);
      bus.iReady_BM_State0     = (st_cnt >= st_lat);
      if (wb_stall) begin
        check("wb_hold_valid", WWB'(bus.oValid_BM_WeightBias), WWB'(1));
        check("wb_hold_data", bus.oData_BM_WeightBias, wb_prev);
      end
      if (st_stall) begin
        check("st_hold_valid", WWB'(bus.oValid_BM_State0), WWB'(1));
        check("st_hold_data", WWB'(bus.oData_BM_State0), WWB'(st_prev));
      end
      if (bus.oValid_BM_WeightBias && bus.iReady_BM_WeightBias) begin
        if (wb_exp_q.size() > 0) begin
          check("wb_data", bus.oData_BM_WeightBias, wb_exp_q.pop_front());
          check("wb_tile", WWB'(bus.oTile), WWB'(tile_exp_q.pop_front()));
        end else check("wb_extra_handshake", WWB'(wb_exp_q.size()), WWB'(1));
      end
      if (bus.oValid_BM_State0 && bus.iReady_BM_State0) begin
        if (st_exp_q.size() > 0) check("st_data", WWB'(bus.oData_BM_State0), WWB'(st_exp_q.pop_front()));
        else check("st_extra_handshake", WWB'(st_exp_q.size()), WWB'(1));
      end
      wb_stall = bus.oValid_BM_WeightBias & ~bus.iReady_BM_WeightBias;
      st_stall = bus.oValid_BM_State0 & ~bus.iReady_BM_State0;
      wb_prev  = bus.oData_BM_WeightBias;
      st_prev  = bus.oData_BM_State0;
      if (bus.oValid_BM_WeightBias) wb_cnt = bus.iReady_BM_WeightBias ? 0 : wb_cnt + 1;
      if (bus.oValid_BM_State0) st_cnt = bus.iReady_BM_State0 ? 0 : st_cnt + 1;
      if (!bus.oBusy) fetch_k = 0;
      if (bus.oRdEn) begin
        check("rd_addr", WWB'(bus.oRdAddr), WWB'(fetch_k));
        check("rd_tile", WWB'(bus.oTile), WWB'(fetch_k));
        check("rd_no_valid", WWB'(bus.oValid_BM_WeightBias | bus.oValid_BM_State0), WWB'(0));
        fetch_k++;
      end
    end
    if (bus_b.oRdEn) addr_b_q.push_back(bus_b.oRdAddr);
    if (bus_b.oDone) done_b++;
  end

  // Presents a vector until it is accepted, then queues the expected tile stream.
  task automatic accept_vec(input logic [SW-1:0] s, output bit ok);
    ok = 1'b0;
    bus.iValid_AM_State = 1'b1;
    bus.iData_AM_State  = s;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (bus.oReady_AM_State) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_seen", WWB'(ok), WWB'(1));
    if (ok) begin
      for (int k = 0; k < NT; k++) begin
        wb_exp_q.push_back(WWB'(16 + k));
        tile_exp_q.push_back(TW'(k));
        st_exp_q.push_back(s);
      end
    end
  endtask

  // Counts cycles after acceptance up to the oDone pulse.
  task automatic wait_done(input int exp_n, input bit keep, input logic [SW-1:0] next_s,
                           input string name);
    int n;
    bit seen;
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (keep) bus.iData_AM_State = next_s;
        else bus.iValid_AM_State = 1'b0;
      end
      #1;
      if (n == 1) begin
        check("lat_rden", WWB'(bus.oRdEn), WWB'(1));
        check("lat_busy", WWB'(bus.oBusy), WWB'(1));
        check("lat_state_fetch", WWB'(bus.dbg_state), WWB'(1));
        check("lat_ready_low", WWB'(bus.oReady_AM_State), WWB'(0));
      end
      if (n == 3) begin
        check("lat_wb_valid", WWB'(bus.oValid_BM_WeightBias), WWB'(1));
        check("lat_st_valid", WWB'(bus.oValid_BM_State0), WWB'(1));
      end
      if (bus.oDone) begin seen = 1'b1; break; end
    end
    check({name, "_done_seen"}, WWB'(seen), WWB'(1));
    check({name, "_done_cycle"}, WWB'(n), WWB'(exp_n));
    check({name, "_no_accept_on_done"}, WWB'(bus.oReady_AM_State), WWB'(0));
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"}, WWB'(bus.oReady_AM_State), WWB'(1));
    check({name, "_busy"}, WWB'(bus.oBusy), WWB'(0));
    check({name, "_wb_q_empty"}, WWB'(wb_exp_q.size()), WWB'(0));
    check({name, "_st_q_empty"}, WWB'(st_exp_q.size()), WWB'(0));
  endtask

  typedef struct {
    logic [SW-1:0] s;
    int            wb_lat;
    int            st_lat;
    int            exp_done;
  } vec_t;

  vec_t vecs[5];
  bit   ok;
  logic [AW-1:0] exp_addr_b[3];

  initial begin
    // Cycles to oDone = NT * (3 + max sink latency).
    vecs[0] = '{16'hA5A5, 0, 0, 9};
    vecs[1] = '{16'h1234, 5, 0, 24};
    vecs[2] = '{16'hBEEF, 2, 0, 15};
    vecs[3] = '{16'h0F0F, 0, 3, 18};
    vecs[4] = '{16'hFFFF, 1, 1, 12};
    exp_addr_b[0] = 8'd254; exp_addr_b[1] = 8'd255; exp_addr_b[2] = 8'd0;

    bus.iValid_AM_State = 1'b0; bus.iData_AM_State = '0;
    bus.iReady_BM_WeightBias = 1'b0; bus.iReady_BM_State0 = 1'b0;
    bus_b.iValid_AM_State = 1'b0; bus_b.iData_AM_State = '0; bus_b.iRdData = '0;
    bus_b.iReady_BM_WeightBias = 1'b1; bus_b.iReady_BM_State0 = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", WWB'(bus.oReady_AM_State), WWB'(0));
    check("rst_busy", WWB'(bus.oBusy), WWB'(0));
    check("rst_valids", WWB'({bus.oValid_BM_WeightBias, bus.oValid_BM_State0}), WWB'(0));
    check("rst_rden", WWB'(bus.oRdEn), WWB'(0));
    check("rst_done", WWB'(bus.oDone), WWB'(0));
    check("rst_tile", WWB'(bus.oTile), WWB'(0));
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk); #1;
    check_idle("post_rst");
    check("post_rst_state", WWB'(bus.dbg_state), WWB'(0));

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      wb_lat = vecs[i].wb_lat;
      st_lat = vecs[i].st_lat;
      accept_vec(vecs[i].s, ok);
      wait_done(vecs[i].exp_done, 1'b0, '0, $sformatf("vec%0d", i));
      @(negedge clk); #1;
      check_idle($sformatf("vec%0d_idle", i));
    end

    // Valid held high across two vectors: second accepted the cycle after oDone
    wb_lat = 0; st_lat = 0;
    accept_vec(16'h1111, ok);
    wait_done(9, 1'b1, 16'h2222, "b2b_a");
    @(negedge clk); #1;
    check("b2b_gap_ready", WWB'(bus.oReady_AM_State), WWB'(1));
    accept_vec(16'h2222, ok);
    wait_done(9, 1'b0, '0, "b2b_b");
    @(negedge clk); #1;
    check_idle("b2b_idle");

    // Reset during ISSUE of tile 1
    wb_lat = 3; st_lat = 0;
    accept_vec(16'h5A5A, ok);
    @(negedge clk);
    bus.iValid_AM_State = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.oTile == TW'(1) && bus.oValid_BM_WeightBias) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_rst_reach_tile1", WWB'(ok), WWB'(1));
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valids", WWB'({bus.oValid_BM_WeightBias, bus.oValid_BM_State0}), WWB'(0));
    check("mid_rst_busy", WWB'(bus.oBusy), WWB'(0));
    check("mid_rst_ready", WWB'(bus.oReady_AM_State), WWB'(1));
    wb_exp_q.delete(); st_exp_q.delete(); tile_exp_q.delete();
    accept_vec(16'h7E7E, ok);
    wait_done(18, 1'b0, '0, "restart");
    @(negedge clk); #1;
    check_idle("restart_idle");

    // Address wrap on the BASE=254 instance
    @(negedge clk);
    bus_b.iValid_AM_State = 1'b1;
    bus_b.iData_AM_State  = 16'hC3C3;
    #1;
    check("wrap_ready", WWB'(bus_b.oReady_AM_State), WWB'(1));
    @(negedge clk);
    bus_b.iValid_AM_State = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("wrap_count", WWB'(addr_b_q.size()), WWB'(3));
    for (int k = 0; k < 3; k++) begin
      if (addr_b_q.size() > 0) check($sformatf("wrap_addr%0d", k), WWB'(addr_b_q.pop_front()), WWB'(exp_addr_b[k]));
    end
    check("wrap_done", WWB'(done_b), WWB'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
